// File: rtl/core_biu_arb_pkg.sv
// ============================================================================
// core_biu_arb_pkg : shared widths, FSM/owner encodings and grant indices
// Rev 1.0
// ============================================================================
`default_nettype none

package core_biu_arb_pkg;

  localparam int CORE_XLEN     = 32;
  localparam int CORE_PC_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  localparam int GNT_LSU = 0;
  localparam int GNT_IFU = 1;

  // Counter must hold the value IFU_STARVE_MAX itself; never narrower than 1 bit.
  function automatic int starve_cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_biu_arb_if.sv
// ============================================================================
// core_biu_arb_if : IFU / LSU request-response ports and shared memory port
// Rev 1.0
// ============================================================================
`default_nettype none

interface core_biu_arb_if
  import core_biu_arb_pkg::*;
#(
  parameter int ADDR_W = CORE_PC_WIDTH,
  parameter int DATA_W = CORE_XLEN
);
  localparam int STRB_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rsp_data;
  logic              ifu_rsp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [STRB_W-1:0] lsu_req_wstrb;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rsp_rdata;
  logic              lsu_rsp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/core_biu_arb_prio.sv
// ============================================================================
// core_biu_arb_prio : combinational IFU/LSU priority select, one-hot grant
// Rev 1.0
// ============================================================================
`default_nettype none

module core_biu_arb_prio
  import core_biu_arb_pkg::*;
(
  input  logic       i_ifu_valid,
  input  logic       i_lsu_valid,
  input  logic       i_flush,
  input  logic       i_starve_full,
  output logic [1:0] o_grant
);

  // LSU wins unless the IFU has been starved; a flushed fetch is never granted.
  always_comb begin
    o_grant = '0;
    if (i_lsu_valid && !i_starve_full) begin
      o_grant[GNT_LSU] = 1'b1;
    end else if (i_ifu_valid && !i_flush) begin
      o_grant[GNT_IFU] = 1'b1;
    end else if (i_lsu_valid) begin
      o_grant[GNT_LSU] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_biu_arb.sv
// ============================================================================
// core_biu_arb : single-outstanding IFU/LSU arbiter onto a shared memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module core_biu_arb
  import core_biu_arb_pkg::*;
#(
  parameter int ADDR_W         = CORE_PC_WIDTH,
  parameter int DATA_W         = CORE_XLEN,
  parameter int IFU_STARVE_MAX = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pipe_flush_req,
  core_biu_arb_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = starve_cnt_w(IFU_STARVE_MAX);

  state_e             r_state;
  state_e             w_state_nxt;
  owner_e             r_owner;
  logic               r_drop;
  logic [CNT_W-1:0]   r_starve;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wen;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_wstrb;

  logic [1:0]         w_grant;
  logic               w_starve_full;
  logic               w_gnt_ifu;
  logic               w_gnt_lsu;

  assign w_starve_full = (r_starve >= CNT_W'(IFU_STARVE_MAX));

  core_biu_arb_prio u_prio (
    .i_ifu_valid   (bus.ifu_req_valid),
    .i_lsu_valid   (bus.lsu_req_valid),
    .i_flush       (i_pipe_flush_req),
    .i_starve_full (w_starve_full),
    .o_grant       (w_grant)
  );

  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wen   = r_wen;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wstrb = r_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_ifu         = 1'b0;
    w_gnt_lsu         = 1'b0;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.ifu_rsp_err   = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rsp_rdata = '0;
    bus.lsu_rsp_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_ifu         = w_grant[GNT_IFU];
        w_gnt_lsu         = w_grant[GNT_LSU];
        bus.ifu_req_ready = w_gnt_ifu;
        bus.lsu_req_ready = w_gnt_lsu;
        if (w_gnt_ifu || w_gnt_lsu) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_rsp_valid) begin
          w_state_nxt = ST_IDLE;
          if (r_owner == OWN_LSU) begin
            bus.lsu_rsp_valid = 1'b1;
            bus.lsu_rsp_rdata = bus.mem_rsp_data;
            bus.lsu_rsp_err   = bus.mem_rsp_err;
          end else if (!r_drop && !i_pipe_flush_req) begin
            bus.ifu_rsp_valid = 1'b1;
            bus.ifu_rsp_data  = bus.mem_rsp_data;
            bus.ifu_rsp_err   = bus.mem_rsp_err;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_NONE;
      r_drop   <= 1'b0;
      r_starve <= '0;
      r_addr   <= '0;
      r_wen    <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (w_gnt_ifu) begin
        r_owner <= OWN_IFU;
        r_addr  <= bus.ifu_req_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wstrb <= '0;
      end else if (w_gnt_lsu) begin
        r_owner <= OWN_LSU;
        r_addr  <= bus.lsu_req_addr;
        r_wen   <= bus.lsu_req_wen;
        r_wdata <= bus.lsu_req_wdata;
        r_wstrb <= bus.lsu_req_wstrb;
      end

      // Drop only matters while a fetch is in flight; it dies with the transaction.
      if (w_state_nxt == ST_IDLE || r_state == ST_IDLE) begin
        r_drop <= 1'b0;
      end else if (r_owner == OWN_IFU && i_pipe_flush_req) begin
        r_drop <= 1'b1;
      end

      if (w_gnt_ifu) begin
        r_starve <= '0;
      end else if (w_gnt_lsu && bus.ifu_req_valid && !w_starve_full) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
